// File: rtl/key_event_ctrl.sv
// key_event_ctrl: synchronises and debounces active-low push-button lines,
// latches press events into a sticky capture register with a press counter,
// and raises a maskable level interrupt. Software access is through a small
// Avalon-MM slave with one-cycle registered read data.
module key_event_ctrl #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] in_port,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                irq
);

    typedef enum logic {
        STABLE = 1'b0,
        VERIFY = 1'b1
    } db_state_t;

    // Terminal count of the debounce window (window length minus one).
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_LEVEL   = 2'd0;
    localparam logic [1:0] ADDR_CAPTURE = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    logic [NUM_KEYS-1:0] sync1_reg;
    logic [NUM_KEYS-1:0] sync2_reg;
    logic [NUM_KEYS-1:0] pressed_s;
    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] rise;

    // Two-flop synchroniser; resets to the released (high) level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    assign pressed_s = ~sync2_reg;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            db_state_t        state_reg;
            db_state_t        state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             level_reg;
            logic             level_next;

            // Per-key debounce state, window counter and accepted level.
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg <= STABLE;
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                    level_reg <= level_next;
                end
            end

            // A change is accepted only after a full window of identical samples;
            // any sample agreeing with the current level restarts the window.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                level_next = level_reg;
                case (state_reg)
                    STABLE: begin
                        cnt_next = '0;
                        if (pressed_s[gi] != level_reg) begin
                            state_next = VERIFY;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    VERIFY: begin
                        if (pressed_s[gi] == level_reg) begin
                            state_next = STABLE;
                            cnt_next   = '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            level_next = ~level_reg;
                            state_next = STABLE;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end
                endcase
            end

            assign level[gi] = level_reg;
            // Press event is taken from the next-level so capture/count update
            // on the same edge as the level itself.
            assign rise[gi]  = level_next & ~level_reg;
        end
    endgenerate

    logic [NUM_KEYS-1:0] capture_reg;
    logic [NUM_KEYS-1:0] capture_next;
    logic [NUM_KEYS-1:0] mask_reg;
    logic [NUM_KEYS-1:0] mask_next;
    logic [7:0]          count_reg;
    logic [7:0]          count_next;
    logic [7:0]          press_num;
    logic [31:0]         rd_mux;
    logic                wr_en;
    logic                unused_wdata;

    assign wr_en        = chipselect & write;
    assign unused_wdata = ^writedata;

    // Number of keys reporting a press in this cycle.
    always_comb begin
        press_num = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            press_num = press_num + 8'(rise[i]);
        end
    end

    // Register update rules: event sets beat W1C, a COUNT write reloads with
    // this cycle's event count, otherwise events accumulate with wrap.
    always_comb begin
        capture_next = capture_reg;
        mask_next    = mask_reg;
        count_next   = count_reg + press_num;
        if (wr_en && address == ADDR_CAPTURE) begin
            capture_next = capture_reg & ~writedata[NUM_KEYS-1:0];
        end
        capture_next = capture_next | rise;
        if (wr_en && address == ADDR_MASK) begin
            mask_next = writedata[NUM_KEYS-1:0];
        end
        if (wr_en && address == ADDR_COUNT) begin
            count_next = press_num;
        end
    end

    // Read multiplexer over the four registers, zero-extended to the bus.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_LEVEL:   rd_mux = 32'(level);
            ADDR_CAPTURE: rd_mux = 32'(capture_reg);
            ADDR_MASK:    rd_mux = 32'(mask_reg);
            ADDR_COUNT:   rd_mux = 32'(count_reg);
            default:      rd_mux = '0;
        endcase
    end

    // Software-visible registers, registered read data and interrupt.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_reg <= '0;
            mask_reg    <= '0;
            count_reg   <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            capture_reg <= capture_next;
            mask_reg    <= mask_next;
            count_reg   <= count_next;
            readdata    <= (chipselect && read) ? rd_mux : 32'd0;
            irq         <= |(capture_reg & mask_reg);
        end
    end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: directed key/bus stimulus, a window-based
// behavioural model compared every cycle, plus hand-computed expectations.
module tb_key_event_ctrl;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] in_port;
    logic [1:0]    address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    int total = 0;
    int bad   = 0;

    key_event_ctrl #(
        .NUM_KEYS       (NK),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_port   (in_port),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a key's level flips once the last DB synchronised
    // samples since reset all disagree with it.
    // ------------------------------------------------------------------
    logic [NK-1:0] m_dl1, m_dl2, m_lvl, m_cap, m_mask;
    logic [NK-1:0] m_s, m_nlvl, m_rise;
    logic [NK-1:0] hist[$];
    logic [7:0]    m_cnt;
    logic [31:0]   m_rd;
    logic          m_irq;
    logic          m_wr;
    logic          m_all;
    bit            model_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_dl1  = '1;
            m_dl2  = '1;
            hist.delete();
            m_lvl  = '0;
            m_cap  = '0;
            m_mask = '0;
            m_cnt  = '0;
            m_rd   = '0;
            m_irq  = 1'b0;
            model_valid = 1'b1;
        end else begin
            m_s   = ~m_dl2;
            m_dl2 = m_dl1;
            m_dl1 = in_port;
            hist.push_back(m_s);
            if (hist.size() > DB) void'(hist.pop_front());
            m_nlvl = m_lvl;
            if (hist.size() == DB) begin
                for (int k = 0; k < NK; k++) begin
                    m_all = 1'b1;
                    for (int i = 0; i < DB; i++) begin
                        if (hist[i][k] == m_lvl[k]) m_all = 1'b0;
                    end
                    if (m_all) m_nlvl[k] = ~m_lvl[k];
                end
            end
            m_rise = m_nlvl & ~m_lvl;
            if (chipselect && read) begin
                case (address)
                    2'd0:    m_rd = {30'd0, m_lvl};
                    2'd1:    m_rd = {30'd0, m_cap};
                    2'd2:    m_rd = {30'd0, m_mask};
                    default: m_rd = {24'd0, m_cnt};
                endcase
            end else begin
                m_rd = '0;
            end
            m_irq = |(m_cap & m_mask);
            m_wr  = chipselect && write;
            if (m_wr && address == 2'd1) m_cap = m_cap & ~writedata[NK-1:0];
            m_cap = m_cap | m_rise;
            if (m_wr && address == 2'd2) m_mask = writedata[NK-1:0];
            if (m_wr && address == 2'd3) m_cnt = 8'($countones(m_rise));
            else                         m_cnt = m_cnt + 8'($countones(m_rise));
            m_lvl = m_nlvl;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = a;
        tick(1);
        chipselect = 1'b0;
        read       = 1'b0;
        d          = readdata;
        $display("read  addr=%0d data=0x%0h irq=%0b t=%0t", a, d, irq, $time);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = a;
        writedata  = data;
        tick(1);
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        $display("write addr=%0d data=0x%0h irq=%0b t=%0t", a, data, irq, $time);
    endtask

    task automatic read_expect(input logic [1:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_port    = '1;
        address    = '0;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        writedata  = '0;
        @(posedge clk);
        #1;
        tick(2);
        reset = 1'b0;

        // Reset defaults
        read_expect(2'd0, 32'd0, "rst_level");
        read_expect(2'd1, 32'd0, "rst_capture");
        read_expect(2'd2, 32'd0, "rst_mask");
        read_expect(2'd3, 32'd0, "rst_count");
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Clean press of key 0 with MASK enabled
        bus_write(2'd2, 32'h1);
        read_expect(2'd2, 32'h1, "mask_readback");
        in_port = 2'b10;
        tick(5);
        read_expect(2'd0, 32'h0, "press_level_edge6_pre");
        check("press_irq_pre", {31'd0, irq}, 32'd0);
        read_expect(2'd0, 32'h1, "press_level_after6");
        check("press_irq_rise", {31'd0, irq}, 32'd1);
        read_expect(2'd1, 32'h1, "press_capture");
        read_expect(2'd3, 32'd1, "press_count");

        // Release, clear, then bounce on key 1
        in_port = 2'b11;
        tick(8);
        bus_write(2'd1, 32'h3);
        bus_write(2'd3, 32'h0);
        in_port = 2'b01; tick(3);
        in_port = 2'b11; tick(1);
        in_port = 2'b01; tick(3);
        in_port = 2'b11; tick(6);
        read_expect(2'd0, 32'h0, "bounce_level");
        read_expect(2'd1, 32'h0, "bounce_capture");
        read_expect(2'd3, 32'h0, "bounce_count");

        // W1C colliding with key 1 press while CAPTURE = 0x1
        in_port = 2'b10; tick(8);
        in_port = 2'b11; tick(8);
        in_port = 2'b01;
        tick(4);
        read_expect(2'd0, 32'h0, "collide_level_pre");
        bus_write(2'd1, 32'h3);
        read_expect(2'd0, 32'h2, "collide_level");
        check("collide_irq_drop", {31'd0, irq}, 32'd0);
        read_expect(2'd1, 32'h2, "collide_capture");
        read_expect(2'd3, 32'd2, "collide_count");

        // Preload COUNT to 254 with paired presses, then wrap
        in_port = 2'b11;
        tick(8);
        for (int r = 0; r < 126; r++) begin
            in_port = 2'b00; tick(7);
            in_port = 2'b11; tick(7);
        end
        read_expect(2'd3, 32'd254, "preload_count");
        in_port = 2'b00;
        tick(5);
        read_expect(2'd3, 32'd254, "wrap_count_pre");
        read_expect(2'd3, 32'd0, "wrap_count");
        read_expect(2'd0, 32'h3, "both_level");
        in_port = 2'b11;
        tick(8);
        in_port = 2'b10;
        tick(5);
        bus_write(2'd3, 32'hFFFF_FFFF);
        read_expect(2'd3, 32'd1, "write_with_event_count");

        // Reset in the middle of a key 1 debounce window
        in_port = 2'b11;
        tick(8);
        in_port = 2'b01;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
        read_expect(2'd0, 32'h0, "rst_mid_edge5");
        read_expect(2'd0, 32'h0, "rst_mid_edge6_pre");
        read_expect(2'd0, 32'h2, "rst_mid_level");
        read_expect(2'd1, 32'h2, "rst_mid_capture");

        // MASK enables and then drops irq while CAPTURE stays set
        bus_write(2'd2, 32'h2);
        check("mask_irq_pre", {31'd0, irq}, 32'd0);
        tick(1);
        check("mask_irq_on", {31'd0, irq}, 32'd1);
        bus_write(2'd2, 32'h0);
        check("mask_irq_hold", {31'd0, irq}, 32'd1);
        tick(1);
        check("mask_irq_off", {31'd0, irq}, 32'd0);
        read_expect(2'd1, 32'h2, "mask_capture_kept");

        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
